mac_rx_frame: RTL and testbench
===============================

// Module: mac_rx_frame
// PURPOSE
//  Receive-side MAC framer, counterpart of mac_tx. Takes the GMII byte stream, finds preamble/SFD,
//  filters on destination MAC, decodes EtherType (IP/ARP), strips header+FCS, forwards payload to
//  ip_rx/arp_rx, checks FCS, and reports one good/bad status pulse per accepted frame.
// PARAMETERS
//  PREAMBLE_MIN  4     min 0x55 bytes before 0xD5 (SFD) to accept a frame
//  MAX_FRAME     1518  max bytes dest..FCS; exceeding this is an error
//  MIN_FRAME     64    min bytes dest..FCS; fewer is a runt (bad)
// PORTS
//  clk                 in   1   rx clock (GMII rx clock domain)
//  rst_n               in   1   asynchronous, active-low reset
//  local_mac_addr      in   48  own MAC; frames to it or FF:FF:FF:FF:FF:FF accepted
//  gmii_rx_dv          in   1   GMII data valid
//  gmii_rx_data        in   8   GMII data byte
//  rx_source_mac_addr  out  48  source MAC of last accepted header
//  upper_type          out  2   01=IPv4 (0x0800), 10=ARP (0x0806), 00=none
//  upper_frame_start   out  1   1-cycle pulse with first payload byte
//  upper_data_valid    out  1   payload byte valid
//  upper_data          out  8   payload byte (FCS never forwarded)
//  frame_good          out  1   1-cycle pulse: FCS ok, length in range
//  frame_bad           out  1   1-cycle pulse: FCS mismatch, runt or oversize
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, delay line cleared; async assert, sync release.
//  Inputs registered once; all decisions on registered byte/dv.
//  FSM: IDLE -> PREAMBLE on dv&&0x55. PREAMBLE: count 0x55; 0xD5 with count>=PREAMBLE_MIN -> HEADER,
//   any other byte or dv low -> DROP/IDLE. HEADER: 14 bytes (dest6, src6, type2), byte_cnt 0..13.
//   After dest byte 5: mismatch (not local, not broadcast) -> DROP. After type byte 13: 0x0800/0x0806
//   -> PAYLOAD, set upper_type and rx_source_mac_addr; other EtherType -> DROP.
//   PAYLOAD: until dv low -> CHECK (1 cycle) -> IDLE. DROP: wait dv low -> IDLE, no status pulse.
//  dv low during PREAMBLE/HEADER: silent abort, no pulse, no payload emitted.
//  Delay line: 4-byte shift reg loaded from first dest byte on; byte leaving it feeds crc (Enable)
//   so at dv fall crc covers dest..payload and delay line holds received FCS.
//  crc Reset asserted in IDLE and PREAMBLE. Payload byte i (i>=0 after EtherType) on upper_data
//   the cycle after GMII byte i+4 is registered; upper_frame_start with i=0.
//  CHECK: compare delay line vs crc_result using the same byte mapping mac_tx uses to emit FCS.
//   frame_good iff match && MIN_FRAME<=byte_cnt<=MAX_FRAME; else frame_bad. Exactly one pulse.
//  byte_cnt 11 bits, saturating. byte_cnt>MAX_FRAME in PAYLOAD: stop forwarding, pulse frame_bad
//   immediately, -> DROP (no second pulse at dv fall). Oversize takes precedence if same cycle as dv fall.
//  upper_type held until next header accept or reset; rx_source_mac_addr likewise.
//  New 0x55 while in CHECK is ignored (IFG assumed >=1 cycle); next frame starts from IDLE.
// STRUCTURE
//  mac_rx_pkg: FSM state enum (IDLE,PREAMBLE,HEADER,PAYLOAD,CHECK,DROP), ETH_SFD, ETH_TYPE_IP,
//   ETH_TYPE_ARP, BROADCAST_MAC, fcs_byte(crc,k) function shared with mac_tx.
//  One sub-module instance: existing crc (Clk,Reset,Data_in,Enable,Crc). Everything else inline.
// TESTING
//  1 Unicast IP frame to local MAC, 46B payload 0x00..0x2D, valid FCS -> 46 upper_data_valid
//    cycles 0x00..0x2D, upper_type=01, start on byte 0x00, frame_good once, no FCS bytes out.
//  2 Broadcast ARP (type 0x0806, 28B+18B pad) -> upper_type=10, rx_source_mac_addr latched,
//    frame_good once.
//  3 Frame to other MAC 02:00:00:00:00:99 -> no upper_data_valid, no good/bad pulse.
//  4 Frame 1 with last FCS byte flipped -> payload forwarded, frame_bad once, frame_good never.
//  5 1600-byte frame -> frame_bad at byte 1519, forwarding stops, no further pulse;
//    30-byte runt with valid FCS -> frame_bad.
//  6 rst_n low mid-payload -> all outputs 0 at once; next valid frame received good.

Source files
------------

// File: rtl/mac_rx_pkg.sv
// Shared types and constants for the receive-side MAC framer.
// fcs_byte gives the on-wire FCS byte k (k=0 first) for a running crc value.
package mac_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    CHECK,
    DROP
  } state_t;

  localparam logic [7:0]  ETH_PRE       = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  function automatic logic [7:0] fcs_byte(
    input logic [31:0] crc,
    input logic [1:0]  k
  );
    return ~crc[8*k +: 8];
  endfunction

endpackage

// File: rtl/crc.sv
// Ethernet CRC-32, reflected, LSB-first per byte, seeded to all ones.
// Reset is synchronous so the framer can hold it from its FSM state.
module crc (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  Data_in,
  input  logic        Enable,
  output logic [31:0] Crc
);

  function automatic logic [31:0] step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB8_8320 : 32'h0);
    end
    return r;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset)
      Crc <= 32'hFFFF_FFFF;
    else if (Enable)
      Crc <= step(Crc, Data_in);
  end

endmodule

// File: rtl/mac_rx_frame.sv
// GMII receive framer: preamble/SFD hunt, address and EtherType filter,
// 4-byte delay line so the FCS is never forwarded, and FCS/length check.
module mac_rx_frame
  import mac_rx_pkg::*;
#(
  parameter int PREAMBLE_MIN = 4,
  parameter int MAX_FRAME    = 1518,
  parameter int MIN_FRAME    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] local_mac_addr,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rx_data,
  output logic [47:0] rx_source_mac_addr,
  output logic [1:0]  upper_type,
  output logic        upper_frame_start,
  output logic        upper_data_valid,
  output logic [7:0]  upper_data,
  output logic        frame_good,
  output logic        frame_bad
);

  localparam logic [3:0]  PRE_C = 4'(PREAMBLE_MIN);
  localparam logic [10:0] MAX_C = 11'(MAX_FRAME);
  localparam logic [10:0] MIN_C = 11'(MIN_FRAME);

  logic [1:0]  rst_sh;
  logic        rst_i;
  logic        dv_r;
  logic [7:0]  data_r;
  state_t      state, state_nxt;
  logic [3:0]  pre_cnt;
  logic [10:0] byte_cnt;
  logic [47:0] addr_sh;
  logic [7:0]  type_hi;
  logic [31:0] dl;
  logic [31:0] crc_val;
  logic        crc_rst, crc_en;
  logic        shift, fwd, accept;
  logic        over, dest_ok, fcs_ok, len_ok;
  logic [15:0] eth_type;
  logic [1:0]  type_code;

  // Async assert, synchronous release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sh <= 2'b00;
    else        rst_sh <= {rst_sh[0], 1'b1};
  end
  assign rst_i = rst_sh[1];

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      dv_r   <= 1'b0;
      data_r <= 8'h00;
    end else begin
      dv_r   <= gmii_rx_dv;
      data_r <= gmii_rx_data;
    end
  end

  assign dest_ok = ({addr_sh[39:0], data_r} == local_mac_addr)
                || ({addr_sh[39:0], data_r} == BROADCAST_MAC);
  assign eth_type  = {type_hi, data_r};
  assign type_code = (eth_type == ETH_TYPE_IP)  ? 2'b01 :
                     (eth_type == ETH_TYPE_ARP) ? 2'b10 : 2'b00;
  assign over   = byte_cnt > MAX_C;
  assign len_ok = (byte_cnt >= MIN_C) && !over;
  assign fcs_ok = (dl[31:24] == fcs_byte(crc_val, 2'd0))
               && (dl[23:16] == fcs_byte(crc_val, 2'd1))
               && (dl[15:8]  == fcs_byte(crc_val, 2'd2))
               && (dl[7:0]   == fcs_byte(crc_val, 2'd3));

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    crc_rst   = 1'b0;
    shift     = 1'b0;
    fwd       = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        crc_rst = 1'b1;
        if (dv_r && data_r == ETH_PRE) state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
        crc_rst = 1'b1;
        if (!dv_r)
          state_nxt = IDLE;
        else if (data_r == ETH_SFD && pre_cnt >= PRE_C)
          state_nxt = HEADER;
        else if (data_r != ETH_PRE)
          state_nxt = DROP;
      end
      HEADER: begin
        if (!dv_r) begin
          state_nxt = IDLE;
        end else begin
          shift = 1'b1;
          if (byte_cnt == 11'd5 && !dest_ok) begin
            state_nxt = DROP;
          end else if (byte_cnt == 11'd13) begin
            accept    = type_code != 2'b00;
            state_nxt = accept ? PAYLOAD : DROP;
          end
        end
      end
      PAYLOAD: begin
        if (over) begin
          state_nxt = DROP;
        end else if (!dv_r) begin
          state_nxt = CHECK;
        end else begin
          shift = 1'b1;
          fwd   = byte_cnt >= 11'd18;
        end
      end
      CHECK: state_nxt = IDLE;
      DROP:  if (!dv_r) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bytes leave the delay line into the crc once it is full.
  assign crc_en = shift && byte_cnt >= 11'd4;

  crc u_crc (
    .Clk     (clk),
    .Reset   (crc_rst),
    .Data_in (dl[31:24]),
    .Enable  (crc_en),
    .Crc     (crc_val)
  );

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      pre_cnt            <= 4'd0;
      byte_cnt           <= 11'd0;
      addr_sh            <= 48'h0;
      type_hi            <= 8'h00;
      dl                 <= 32'h0;
      rx_source_mac_addr <= 48'h0;
      upper_type         <= 2'b00;
      upper_frame_start  <= 1'b0;
      upper_data_valid   <= 1'b0;
      upper_data         <= 8'h00;
      frame_good         <= 1'b0;
      frame_bad          <= 1'b0;
    end else begin
      upper_frame_start <= 1'b0;
      upper_data_valid  <= 1'b0;
      frame_good        <= 1'b0;
      frame_bad         <= 1'b0;
      if (state == IDLE)
        pre_cnt <= 4'd1;
      else if (state == PREAMBLE && data_r == ETH_PRE && pre_cnt != 4'hF)
        pre_cnt <= pre_cnt + 4'd1;
      if (state == PREAMBLE)
        byte_cnt <= 11'd0;
      else if (shift && byte_cnt != 11'h7FF)
        byte_cnt <= byte_cnt + 11'd1;
      if (shift) begin
        dl <= {dl[23:0], data_r};
        if (state == HEADER && byte_cnt < 11'd12)
          addr_sh <= {addr_sh[39:0], data_r};
        if (state == HEADER && byte_cnt == 11'd12)
          type_hi <= data_r;
      end
      if (accept) begin
        rx_source_mac_addr <= addr_sh;
        upper_type         <= type_code;
      end
      if (fwd) begin
        upper_data        <= dl[31:24];
        upper_data_valid  <= 1'b1;
        upper_frame_start <= byte_cnt == 11'd18;
      end
      if (state == PAYLOAD && over) begin
        frame_bad <= 1'b1;
      end else if (state == CHECK) begin
        frame_good <= fcs_ok && len_ok;
        frame_bad  <= !(fcs_ok && len_ok);
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_frame.sv
// Directed bench for mac_rx_frame: builds frames with a reference FCS,
// streams them over GMII and checks payload, type, source and status.
module tb_mac_rx_frame;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] local_mac_addr;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rx_data;
  logic [47:0] rx_source_mac_addr;
  logic [1:0]  upper_type;
  logic        upper_frame_start;
  logic        upper_data_valid;
  logic [7:0]  upper_data;
  logic        frame_good;
  logic        frame_bad;

  localparam logic [47:0] LOCAL = 48'h0200_0000_0001;
  localparam logic [47:0] SRC1  = 48'h0211_2233_4455;
  localparam logic [47:0] SRC2  = 48'h02AA_BBCC_DDEE;
  localparam logic [47:0] OTHER = 48'h0200_0000_0099;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

  mac_rx_frame dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .local_mac_addr     (local_mac_addr),
    .gmii_rx_dv         (gmii_rx_dv),
    .gmii_rx_data       (gmii_rx_data),
    .rx_source_mac_addr (rx_source_mac_addr),
    .upper_type         (upper_type),
    .upper_frame_start  (upper_frame_start),
    .upper_data_valid   (upper_data_valid),
    .upper_data         (upper_data),
    .frame_good         (frame_good),
    .frame_bad          (frame_bad)
  );

  always #5 clk = ~clk;

  logic [7:0] frm[$];
  logic [7:0] rx_q[$];
  int good_cnt = 0;
  int bad_cnt = 0;
  int start_cnt = 0;
  int bad_idx = 0;
  logic [7:0] start_byte = 8'h00;

  int passes = 0;
  int total = 0;
  int b_good, b_bad, b_start, b_rx;

  always @(negedge clk) begin
    if (rst_n) begin
      if (upper_data_valid) rx_q.push_back(upper_data);
      if (upper_frame_start) begin
        start_cnt++;
        start_byte = upper_data;
      end
      if (frame_good) good_cnt++;
      if (frame_bad) begin
        bad_cnt++;
        bad_idx = rx_q.size();
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] crc32();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) begin
      for (int j = 0; j < 8; j++) begin
        if ((c[0] ^ frm[i][j]) == 1'b1) c = (c >> 1) ^ 32'hEDB8_8320;
        else c = c >> 1;
      end
    end
    return c;
  endfunction

  task automatic build(input logic [47:0] dst, input logic [47:0] src,
                       input logic [15:0] typ, input int n, input int kind);
    logic [31:0] c;
    logic [7:0] b;
    frm.delete();
    for (int k = 5; k >= 0; k--) frm.push_back(dst[8*k +: 8]);
    for (int k = 5; k >= 0; k--) frm.push_back(src[8*k +: 8]);
    frm.push_back(typ[15:8]);
    frm.push_back(typ[7:0]);
    for (int i = 0; i < n; i++) begin
      if (kind == 0) b = 8'(i);
      else b = (i < 28) ? 8'(8'h80 + i) : 8'h00;
      frm.push_back(b);
    end
    c = ~crc32();
    for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    gmii_rx_dv = v;
    gmii_rx_data = d;
  endtask

  task automatic send(input int npre, input int nbytes, input bit drop);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < nbytes; i++) drive(1'b1, frm[i]);
    if (drop) repeat (14) drive(1'b0, 8'h00);
  endtask

  task automatic snap();
    b_good = good_cnt;
    b_bad = bad_cnt;
    b_start = start_cnt;
    b_rx = rx_q.size();
  endtask

  int mism;

  initial begin
    rst_n = 1'b0;
    local_mac_addr = LOCAL;
    gmii_rx_dv = 1'b0;
    gmii_rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_type", 64'(upper_type), 64'd0);
    check("rst_src", 64'(rx_source_mac_addr), 64'd0);
    check("rst_valid", 64'(upper_data_valid), 64'd0);
    check("rst_pulses", 64'({frame_good, frame_bad}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) drive(1'b0, 8'h00);

    // 1: unicast IPv4, minimum-size frame
    snap();
    build(LOCAL, SRC1, 16'h0800, 46, 0);
    send(7, frm.size(), 1'b1);
    check("t1_count", 64'(rx_q.size() - b_rx), 64'd46);
    mism = 0;
    for (int i = 0; i < 46; i++)
      if (rx_q.size() > b_rx + i && rx_q[b_rx + i] !== 8'(i)) mism++;
    check("t1_data", 64'(mism), 64'd0);
    check("t1_start", 64'(start_cnt - b_start), 64'd1);
    check("t1_start_byte", 64'(start_byte), 64'h00);
    check("t1_type", 64'(upper_type), 64'd1);
    check("t1_src", 64'(rx_source_mac_addr), 64'(SRC1));
    check("t1_good", 64'(good_cnt - b_good), 64'd1);
    check("t1_bad", 64'(bad_cnt - b_bad), 64'd0);

    // 2: broadcast ARP, preamble at the minimum length
    snap();
    build(BCAST, SRC2, 16'h0806, 46, 1);
    send(4, frm.size(), 1'b1);
    check("t2_type", 64'(upper_type), 64'd2);
    check("t2_src", 64'(rx_source_mac_addr), 64'(SRC2));
    check("t2_good", 64'(good_cnt - b_good), 64'd1);
    check("t2_count", 64'(rx_q.size() - b_rx), 64'd46);
    check("t2_first", 64'(start_byte), 64'h80);

    // 3: other destination is filtered silently
    snap();
    build(OTHER, SRC1, 16'h0800, 46, 0);
    send(7, frm.size(), 1'b1);
    check("t3_count", 64'(rx_q.size() - b_rx), 64'd0);
    check("t3_pulses", 64'((good_cnt - b_good) + (bad_cnt - b_bad)), 64'd0);
    check("t3_type_held", 64'(upper_type), 64'd2);
    check("t3_src_held", 64'(rx_source_mac_addr), 64'(SRC2));

    // short preamble is not a frame
    snap();
    build(LOCAL, SRC1, 16'h0800, 46, 0);
    send(3, frm.size(), 1'b1);
    check("pre3_count", 64'(rx_q.size() - b_rx), 64'd0);
    check("pre3_pulses", 64'((good_cnt - b_good) + (bad_cnt - b_bad)), 64'd0);

    // 4: corrupted last FCS byte
    snap();
    build(LOCAL, SRC1, 16'h0800, 46, 0);
    frm[frm.size() - 1] = frm[frm.size() - 1] ^ 8'hFF;
    send(7, frm.size(), 1'b1);
    check("t4_count", 64'(rx_q.size() - b_rx), 64'd46);
    check("t4_bad", 64'(bad_cnt - b_bad), 64'd1);
    check("t4_good", 64'(good_cnt - b_good), 64'd0);

    // 5a: 1600-byte oversize frame
    snap();
    build(LOCAL, SRC1, 16'h0800, 1582, 0);
    send(7, frm.size(), 1'b1);
    check("t5_bad", 64'(bad_cnt - b_bad), 64'd1);
    check("t5_good", 64'(good_cnt - b_good), 64'd0);
    check("t5_count", 64'(rx_q.size() - b_rx), 64'd1501);
    check("t5_stop", 64'(bad_idx - b_rx), 64'd1501);

    // 5b: 30-byte runt with valid FCS
    snap();
    build(LOCAL, SRC1, 16'h0800, 12, 0);
    send(7, frm.size(), 1'b1);
    check("runt_bad", 64'(bad_cnt - b_bad), 64'd1);
    check("runt_good", 64'(good_cnt - b_good), 64'd0);
    check("runt_count", 64'(rx_q.size() - b_rx), 64'd12);

    // 6: reset in the middle of the payload
    build(LOCAL, SRC1, 16'h0800, 46, 0);
    send(7, 30, 1'b0);
    rst_n = 1'b0;
    #1;
    check("r6_valid", 64'(upper_data_valid), 64'd0);
    check("r6_type", 64'(upper_type), 64'd0);
    check("r6_src", 64'(rx_source_mac_addr), 64'd0);
    check("r6_data", 64'(upper_data), 64'd0);
    gmii_rx_dv = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) drive(1'b0, 8'h00);
    snap();
    send(7, frm.size(), 1'b1);
    check("r6_good", 64'(good_cnt - b_good), 64'd1);
    check("r6_bad", 64'(bad_cnt - b_bad), 64'd0);
    check("r6_count", 64'(rx_q.size() - b_rx), 64'd46);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
